// File: rtl/fft_vis_pkg.sv
// Shared types and widths for the FFT visualizer bar-level path.
package fft_vis_pkg;

  localparam int CPLX_W = 36;
  localparam int HALF_W = 18;
  localparam int MAG_W  = 19;

  typedef struct packed {
    logic signed [HALF_W-1:0] re;
    logic signed [HALF_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {IDLE, CALC, DRAIN, PUBLISH} state_t;

endpackage

// File: rtl/fft_bar_levels_if.sv
// FFT-result / bar-level bus between the FFT core side and fft_bar_levels.
// FFT_BAR_PEAK_HOLD_EN adds the peak_levels signal.
interface fft_bar_levels_if #(
  parameter int NUM_BINS = 16,
  parameter int NUM_BARS = 8,
  parameter int LEVEL_W  = 4
);
  import fft_vis_pkg::*;

  logic                         fft_done;
  logic [NUM_BINS*CPLX_W-1:0]   bins_in;
  logic [NUM_BARS*LEVEL_W-1:0]  bar_levels;
  logic                         bars_valid;
  logic                         busy;
  logic                         overrun;
`ifdef FFT_BAR_PEAK_HOLD_EN
  logic [NUM_BARS*LEVEL_W-1:0]  peak_levels;

  modport master (output fft_done, bins_in,
                  input  bar_levels, bars_valid, busy, overrun, peak_levels);
  modport slave  (input  fft_done, bins_in,
                  output bar_levels, bars_valid, busy, overrun, peak_levels);
`else
  modport master (output fft_done, bins_in,
                  input  bar_levels, bars_valid, busy, overrun);
  modport slave  (input  fft_done, bins_in,
                  output bar_levels, bars_valid, busy, overrun);
`endif

endinterface

// File: rtl/cplx_mag_approx.sv
// Combinational complex magnitude estimate: saturating |re|,|im| then
// alpha-max-beta-min with alpha=1, beta=1/4+1/8.
module cplx_mag_approx
  import fft_vis_pkg::*;
(
  input  cplx_t             bin_i,
  output logic [MAG_W-1:0]  mag_o
);

  function automatic logic [HALF_W-2:0] sat_abs(input logic signed [HALF_W-1:0] x);
    // The most negative code has no positive twin, so clip it to full scale.
    if (x == {1'b1, {(HALF_W-1){1'b0}}}) return '1;
    else if (x < 0)                      return (HALF_W-1)'(-x);
    else                                 return (HALF_W-1)'(x);
  endfunction

  logic [HALF_W-2:0] abs_re, abs_im, mx, mn;

  assign abs_re = sat_abs(bin_i.re);
  assign abs_im = sat_abs(bin_i.im);
  assign mx     = (abs_re >= abs_im) ? abs_re : abs_im;
  assign mn     = (abs_re >= abs_im) ? abs_im : abs_re;
  assign mag_o  = MAG_W'(mx) + MAG_W'(mn >> 2) + MAG_W'(mn >> 3);

endmodule

// File: rtl/fft_bar_levels.sv
// Converts FFT bins 0..NUM_BARS-1 into log-scaled bar heights, one bin per cycle.
// FFT_BAR_PEAK_HOLD_EN adds decaying peak-hold levels.
module fft_bar_levels
  import fft_vis_pkg::*;
#(
  parameter int NUM_BINS  = 16,
  parameter int NUM_BARS  = 8,
  parameter int LEVEL_W   = 4,
  parameter int MAX_LEVEL = 15,
  parameter int LOG_FLOOR = 4
`ifdef FFT_BAR_PEAK_HOLD_EN
  , parameter int DECAY_FRAMES = 2
`endif
) (
  input  logic            clk,
  input  logic            reset,
  fft_bar_levels_if.slave bus
);

  localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);

  state_t                      state_q, state_d;
  logic                        done_q, rise;
  cplx_t                       snap_q   [NUM_BARS];
  logic [LEVEL_W-1:0]          shadow_q [NUM_BARS];
  logic [IDX_W-1:0]            idx_q;
  logic [MAG_W-1:0]            mag_q, mag_w;
  logic [NUM_BARS*LEVEL_W-1:0] bar_q;
  logic                        valid_q, busy_q, overrun_q;

  function automatic logic [LEVEL_W-1:0] mag_to_level(input logic [MAG_W-1:0] m);
    int pos;
    int lvl;
    pos = -1;
    for (int i = 0; i < MAG_W; i++) if (m[i]) pos = i;
    if (pos < 0) return '0;
    lvl = pos + 1 - LOG_FLOOR;
    if (lvl < 0)              lvl = 0;
    else if (lvl > MAX_LEVEL) lvl = MAX_LEVEL;
    return LEVEL_W'(lvl);
  endfunction

  assign rise = bus.fft_done & ~done_q;

  generate
    if (NUM_BARS < NUM_BINS) begin : g_unused_bins
      logic unused_bins;
      assign unused_bins = ^bus.bins_in[NUM_BINS*CPLX_W-1:NUM_BARS*CPLX_W];
    end
  endgenerate

  cplx_mag_approx u_mag (
    .bin_i (snap_q[idx_q]),
    .mag_o (mag_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: defaulting state_d first means every path assigns it, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = CALC;
      CALC:    if (idx_q == LAST_IDX) state_d = DRAIN;
      DRAIN:   state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q    <= 1'b0;
      idx_q     <= '0;
      mag_q     <= '0;
      bar_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      // NOTE: snapshot and shadow are small register arrays, so clearing them on reset is cheap.
      for (int k = 0; k < NUM_BARS; k++) begin
        snap_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates let every register see pre-edge values of the others.
      done_q    <= bus.fft_done;
      valid_q   <= 1'b0;
      overrun_q <= rise && (state_q != IDLE);
      case (state_q)
        IDLE: if (rise) begin
          for (int k = 0; k < NUM_BARS; k++)
            snap_q[k] <= cplx_t'(bus.bins_in[CPLX_W*k +: CPLX_W]);
          idx_q  <= '0;
          busy_q <= 1'b1;
        end
        CALC: begin
          mag_q <= mag_w;
          idx_q <= idx_q + 1'b1;
          // mag_q holds the previous bin's magnitude once the pipeline is primed.
          if (idx_q != '0) shadow_q[idx_q - 1'b1] <= mag_to_level(mag_q);
        end
        DRAIN: shadow_q[NUM_BARS-1] <= mag_to_level(mag_q);
        PUBLISH: begin
          for (int k = 0; k < NUM_BARS; k++)
            bar_q[LEVEL_W*k +: LEVEL_W] <= shadow_q[k];
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.bar_levels = bar_q;
  assign bus.bars_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;

`ifdef FFT_BAR_PEAK_HOLD_EN
  localparam int FC_W = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;

  logic [FC_W-1:0]             frame_cnt_q;
  logic [NUM_BARS*LEVEL_W-1:0] peak_q;
  logic                        tick;

  assign tick = (frame_cnt_q == FC_W'(DECAY_FRAMES - 1));

  // Peaks rise instantly and fall one step every DECAY_FRAMES published frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      peak_q      <= '0;
    end else if (state_q == PUBLISH) begin
      frame_cnt_q <= tick ? '0 : frame_cnt_q + 1'b1;
      for (int k = 0; k < NUM_BARS; k++) begin
        if (shadow_q[k] >= peak_q[LEVEL_W*k +: LEVEL_W])
          peak_q[LEVEL_W*k +: LEVEL_W] <= shadow_q[k];
        else if (tick && (peak_q[LEVEL_W*k +: LEVEL_W] != '0))
          peak_q[LEVEL_W*k +: LEVEL_W] <= peak_q[LEVEL_W*k +: LEVEL_W] - 1'b1;
      end
    end
  end

  assign bus.peak_levels = peak_q;
`endif

endmodule

// File: tb/tb_fft_bar_levels.sv
// Directed self-checking bench for fft_bar_levels; peak-hold case runs only
// when FFT_BAR_PEAK_HOLD_EN is defined.
module tb_fft_bar_levels;
  import fft_vis_pkg::*;

  localparam int NBAR = 8;
  localparam int LW   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fft_bar_levels_if bus ();

  fft_bar_levels dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_bin(input int k, input int re, input int im);
    logic [17:0] r, i;
    r = 18'(re);
    i = 18'(im);
    bus.bins_in[CPLX_W*k +: CPLX_W] = {r, i};
  endtask

  task automatic check_bars(input string tag, input int exp [NBAR]);
    for (int k = 0; k < NBAR; k++)
      check($sformatf("%s_bar%0d", tag, k), int'(bus.bar_levels[LW*k +: LW]), exp[k]);
  endtask

  // Raises fft_done before edge E0; lat = index of the edge after which bars_valid is seen.
  task automatic run_frame(output int lat, output int busy_hi);
    @(negedge clk);
    bus.fft_done = 1'b1;
    lat = -1;
    busy_hi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.busy) busy_hi++;
      if (bus.bars_valid) begin
        lat = k;
        break;
      end
    end
    bus.fft_done = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.fft_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int lat, busy_hi, vcnt, ocnt, vk, ok;
    int exp [NBAR];

    reset = 1'b1;
    bus.fft_done = 1'b0;
    bus.bins_in = '0;
    #1;
    check("rst_bars",    int'(bus.bar_levels), 0);
    check("rst_valid",   int'(bus.bars_valid), 0);
    check("rst_busy",    int'(bus.busy),       0);
    check("rst_overrun", int'(bus.overrun),    0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Case 1: single bin, latency and busy window.
    bus.bins_in = '0;
    set_bin(0, 65536, 0);
    set_bin(9, 5000, 5000);
    run_frame(lat, busy_hi);
    check("c1_latency", lat, 10);
    check("c1_busy_cycles", busy_hi, 10);
    exp = '{13, 0, 0, 0, 0, 0, 0, 0};
    check_bars("c1", exp);
    @(negedge clk);
    check("c1_valid_pulse_width", int'(bus.bars_valid), 0);

    // Cases 2/3: saturation corner, sub-floor magnitudes, mixed signs.
    bus.bins_in = '0;
    set_bin(0, -65536, 32768);
    set_bin(1, -131072, -131072);
    set_bin(2, 3, 4);
    set_bin(3, 0, 131071);
    set_bin(4, -1, 0);
    set_bin(5, 16, 0);
    set_bin(6, 0, -100);
    set_bin(7, 1000, 1000);
    run_frame(lat, busy_hi);
    check("c2_latency", lat, 10);
    exp = '{13, 14, 0, 13, 0, 1, 3, 7};
    check_bars("c2", exp);

    // Case 4a: level held high triggers exactly one frame.
    bus.bins_in = '0;
    set_bin(2, 32768, 0);
    @(negedge clk);
    bus.fft_done = 1'b1;
    vcnt = 0;
    ocnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.bars_valid) vcnt++;
      if (bus.overrun) ocnt++;
    end
    bus.fft_done = 1'b0;
    check("c4_held_valid_count", vcnt, 1);
    check("c4_held_overrun_count", ocnt, 0);
    exp = '{0, 0, 12, 0, 0, 0, 0, 0};
    check_bars("c4_held", exp);

    // Case 4b: second rise while busy is dropped; input changes after capture are ignored.
    bus.bins_in = '0;
    set_bin(4, 1024, 0);
    @(negedge clk);
    bus.fft_done = 1'b1;
    vcnt = 0;
    ocnt = 0;
    vk = -1;
    ok = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.bars_valid) begin vcnt++; vk = k; end
      if (bus.overrun)    begin ocnt++; ok = k; end
      if (k == 1) begin
        set_bin(4, 0, 0);
        set_bin(5, 65536, 0);
      end
      if (k == 4) bus.fft_done = 1'b0;
      if (k == 5) bus.fft_done = 1'b1;
    end
    bus.fft_done = 1'b0;
    check("c4_overrun_count", ocnt, 1);
    check("c4_overrun_edge", ok, 6);
    check("c4_valid_count", vcnt, 1);
    check("c4_valid_edge", vk, 10);
    exp = '{0, 0, 0, 0, 7, 0, 0, 0};
    check_bars("c4_toggle", exp);

    // Case 5: reset mid-frame aborts without a partial update.
    bus.bins_in = '0;
    set_bin(6, 65536, 0);
    @(negedge clk);
    bus.fft_done = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    bus.fft_done = 1'b0;
    #1;
    check("c5_rst_bars",    int'(bus.bar_levels), 0);
    check("c5_rst_valid",   int'(bus.bars_valid), 0);
    check("c5_rst_busy",    int'(bus.busy),       0);
    check("c5_rst_overrun", int'(bus.overrun),    0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.bars_valid) vcnt++;
    end
    check("c5_no_valid_after_abort", vcnt, 0);
    run_frame(lat, busy_hi);
    check("c5_latency", lat, 10);
    exp = '{0, 0, 0, 0, 0, 0, 13, 0};
    check_bars("c5", exp);

`ifdef FFT_BAR_PEAK_HOLD_EN
    // Case 6: peak rises instantly, decays every second frame.
    begin
      int exp_peak [4];
      exp_peak = '{12, 11, 11, 10};
      do_reset();
      for (int f = 0; f < 4; f++) begin
        bus.bins_in = '0;
        if (f == 0) set_bin(0, 32768, 0);
        run_frame(lat, busy_hi);
        check($sformatf("c6_latency_f%0d", f), lat, 10);
        check($sformatf("c6_bar0_f%0d", f), int'(bus.bar_levels[LW-1:0]), (f == 0) ? 12 : 0);
        check($sformatf("c6_peak0_f%0d", f), int'(bus.peak_levels[LW-1:0]), exp_peak[f]);
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
